// File: rtl/decoder_pkg.sv
// Shared types and the one-hot helper for the registered decoder/scan sequencer.
package decoder_pkg;

  // Widest select the helper supports; the decoder truncates to its own OUT_W.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx,
                                                  input logic                 active);
    logic [MAX_OUT_W-1:0] v;
    v = '0;
    if (active) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable; all-zero when disabled.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx,
  input  logic                  active,
  output logic [2**SEL_W-1:0]   d
);

  localparam int OUT_W = 2 ** SEL_W;

  // SEL_W must not exceed MAX_SEL_W; upper helper bits are never set for in-range idx.
  assign d = OUT_W'(onehot(MAX_SEL_W'(idx), active));

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered one-hot decoder with direct-hold and auto-scan modes; outputs decode only
// from registered state, so there is no input-to-output combinational path.
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [SEL_W-1:0]      last,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   d,
  output logic [SEL_W-1:0]      idx,
  output logic                  active,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   idx_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               wrap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // Priority: disable, then load, then scan stepping.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (load) begin
      idx_nxt   = sel;
      cnt_nxt   = '0;
      state_nxt = (mode_t'(mode) == MODE_SCAN) ? ST_SCAN : ST_HOLD;
    end else if (state == ST_SCAN) begin
      // >= lets a live dwell decrease below cnt force an immediate step.
      if (cnt >= dwell) begin
        cnt_nxt = '0;
        if (idx >= last) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx + SEL_W'(1);
        end
      end else begin
        cnt_nxt = cnt + DWELL_W'(1);
      end
    end
  end

  assign active = (state != ST_IDLE);

  decoder_onehot #(
    .SEL_W (SEL_W)
  ) u_dec (
    .idx    (idx),
    .active (active),
    .d      (d)
  );

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed bench for decoder_onehot_seq with SEL_W=3, DWELL_W=8.
module tb_decoder_onehot_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic       mode;
  logic [2:0] sel;
  logic [2:0] last;
  logic [7:0] dwell;
  logic [7:0] d;
  logic [2:0] idx;
  logic       active;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  decoder_onehot_seq #(
    .SEL_W   (3),
    .DWELL_W (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .mode   (mode),
    .sel    (sel),
    .last   (last),
    .dwell  (dwell),
    .d      (d),
    .idx    (idx),
    .active (active),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0;
    sel = 3'd0; last = 3'd0; dwell = 8'd0;
    #12;
    checks++; if (d !== 8'h00)  begin errors++; $display("FAIL reset_d got=%h exp=00", d); end
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    rst_n = 1'b1;
    step();
    en = 1'b1;
    step();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_no_load got=%b exp=0", active); end
  endtask

  task automatic test_direct();
    load = 1'b1; mode = 1'b0; sel = 3'd5;
    step();
    load = 1'b0;
    checks++; if (d !== 8'h20)  begin errors++; $display("FAIL direct_d got=%h exp=20", d); end
    checks++; if (idx !== 3'd5) begin errors++; $display("FAIL direct_idx got=%0d exp=5", idx); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL direct_active got=%b exp=1", active); end
    sel = 3'd2; mode = 1'b1; last = 3'd0; dwell = 8'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (d !== 8'h20 || wrap !== 1'b0) begin
        errors++; $display("FAIL direct_hold[%0d] got d=%h wrap=%b exp d=20 wrap=0", k, d, wrap);
      end
    end
  endtask

  task automatic test_full_scan();
    logic [7:0] exp_d;
    logic       exp_w;
    load = 1'b1; mode = 1'b1; sel = 3'd0; last = 3'd7; dwell = 8'd2;
    step();
    load = 1'b0;
    for (int k = 0; k < 48; k++) begin
      exp_d = 8'h01 << ((k / 3) % 8);
      exp_w = (k > 0) && (k % 24 == 0);
      checks++; if (d !== exp_d) begin
        errors++; $display("FAIL full_scan_d[%0d] got=%h exp=%h", k, d, exp_d);
      end
      checks++; if (wrap !== exp_w) begin
        errors++; $display("FAIL full_scan_wrap[%0d] got=%b exp=%b", k, wrap, exp_w);
      end
      step();
    end
  endtask

  task automatic test_partial_scan();
    int exp_idx[8] = '{6, 0, 1, 2, 0, 1, 2, 0};
    int exp_wrap[8] = '{0, 1, 0, 0, 1, 0, 0, 1};
    load = 1'b1; mode = 1'b1; sel = 3'd6; last = 3'd2; dwell = 8'd0;
    step();
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (idx !== 3'(exp_idx[k]) || wrap !== 1'(exp_wrap[k])) begin
        errors++; $display("FAIL partial_scan[%0d] got idx=%0d wrap=%b exp idx=%0d wrap=%0d",
                           k, idx, wrap, exp_idx[k], exp_wrap[k]);
      end
      step();
    end
  endtask

  task automatic test_dwell_shrink();
    load = 1'b1; mode = 1'b1; sel = 3'd0; last = 3'd7; dwell = 8'd10;
    step();
    load = 1'b0;
    repeat (7) step();
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL shrink_before got=%0d exp=0", idx); end
    dwell = 8'd3;
    step();
    checks++; if (idx !== 3'd1) begin errors++; $display("FAIL shrink_step got=%0d exp=1", idx); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (idx !== 3'd1) begin errors++; $display("FAIL shrink_hold[%0d] got=%0d exp=1", k, idx); end
    end
    step();
    checks++; if (idx !== 3'd2) begin errors++; $display("FAIL shrink_next got=%0d exp=2", idx); end
  endtask

  task automatic test_priority();
    en = 1'b0; load = 1'b1; mode = 1'b1; sel = 3'd6;
    step();
    checks++; if (d !== 8'h00 || active !== 1'b0) begin
      errors++; $display("FAIL prio_idle got d=%h active=%b exp d=00 active=0", d, active);
    end
    checks++; if (idx !== 3'd2) begin errors++; $display("FAIL prio_idx got=%0d exp=2", idx); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL prio_wrap got=%b exp=0", wrap); end
    en = 1'b1; load = 1'b0;
    step();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL prio_stay_idle got=%b exp=0", active); end
    load = 1'b1; mode = 1'b0; sel = 3'd3;
    step();
    load = 1'b0;
    checks++; if (d !== 8'h08 || active !== 1'b1 || idx !== 3'd3) begin
      errors++; $display("FAIL prio_reload got d=%h active=%b idx=%0d exp d=08 active=1 idx=3", d, active, idx);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; mode = 1'b1; sel = 3'd0; last = 3'd7; dwell = 8'd0;
    step();
    load = 1'b0;
    repeat (3) step();
    checks++; if (idx !== 3'd3) begin errors++; $display("FAIL areset_pre got=%0d exp=3", idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (d !== 8'h00 || idx !== 3'd0 || active !== 1'b0) begin
      errors++; $display("FAIL areset_now got d=%h idx=%0d active=%b exp d=00 idx=0 active=0", d, idx, active);
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (wrap !== 1'b0 || active !== 1'b0) begin
        errors++; $display("FAIL areset_after[%0d] got wrap=%b active=%b exp 0 0", k, wrap, active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_full_scan();
    test_partial_scan();
    test_dwell_shrink();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_seq.md
# decoder_onehot_seq

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer. In direct mode it holds the one-hot code of a loaded select value. In scan mode it steps the active output through indices `sel`..`last`, holding each for a programmable dwell, then wraps. It replaces the fixed 3-to-8 combinational decoder wherever a registered, glitch-free or time-multiplexed select is needed, such as display digit scanning or round-robin enables.

## Interface
Parameters:
- `SEL_W`, default 3: select width. `OUT_W = 2**SEL_W` is a derived localparam, not overridable.
- `DWELL_W`, default 8: dwell counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  block enable. Low forces outputs idle.
- `load`  in  1  strobe that captures `sel` and `mode`.
- `mode`  in  1  0 = direct, 1 = scan. Sampled only when `load` is accepted.
- `sel`  in  SEL_W  index to decode (direct) or scan start index (scan).
- `last`  in  SEL_W  scan wrap index. Read live.
- `dwell`  in  DWELL_W  each scan index is held `dwell+1` cycles. Read live.
- `d`  out  OUT_W  one-hot output, or all-zero when idle.
- `idx`  out  SEL_W  current index.
- `active`  out  1  high in HOLD or SCAN.
- `wrap`  out  1  1-cycle pulse on the scan step from `last` (or beyond) back to 0.

## Operation
- States:
  - IDLE: `d=0`, `active=0`.
  - HOLD: direct mode, `d=onehot(idx)`.
  - SCAN: `d=onehot(idx)`, auto-stepping.
- Reset (async, `rst_n=0`): state IDLE, `idx=0`, `cnt=0`, `d=0`, `active=0`, `wrap=0`.
- Priority per cycle, highest first: `en=0`, then `load`, then scan step.
- `en=0`: next state IDLE, `cnt=0`, `idx` retained, `load` ignored.
- `load=1` with `en=1`, from any state:
  - `idx<=sel`, `cnt<=0`.
  - Next state HOLD if `mode=0`, SCAN if `mode=1`.
- HOLD without `load`: everything holds. Changes on `mode`, `last` and `dwell` have no effect.
- SCAN without `load`:
  - If `cnt >= dwell`: step. Set `cnt<=0`. If `idx >= last`, then `idx<=0` and `wrap` pulses. Otherwise `idx<=idx+1`.
  - Else `cnt<=cnt+1`.
  - The `>=` compare means a live decrease of `dwell` below `cnt` forces a step on the next edge. Counter overflow is impossible.
- `sel > last` in scan: first step wraps to 0 and pulses `wrap`. From then on the scan covers 0..`last`.
- `last = 0`, scan: `idx` stays 0 and `wrap` pulses every `dwell+1` cycles.
- `last = OUT_W-1`: full natural cycle of all outputs.
- `dwell = 0`: index advances every cycle.
- IDLE with `load=0`: stays IDLE even if `en=1`.

## Timing
- All outputs are registered, or decoded purely from registered state. There is no combinational path from inputs to outputs.
- Load latency: `d`, `idx` and `active` reflect the captured `sel` on the first edge after `load` is sampled high (1 cycle).
- Scan: each index is visible for exactly `dwell+1` cycles when `dwell` is constant. The start index after `load` also gets the full `dwell+1`.
- `wrap` is high in the same cycle in which `idx` first reads 0 after the wrap. It is never high outside SCAN.
- `en` falling: `d=0` and `active=0` one cycle later.
- `rst_n` asserted mid-scan: outputs clear immediately (asynchronous). The first edge after deassertion behaves as from IDLE.
- `d` is always one-hot or zero. At most one bit is ever set.

## Structure
- Package `decoder_pkg` holds:
  - `mode_t` (DIRECT, SCAN).
  - `state_t` (IDLE, HOLD, SCAN).
  - Function `onehot(idx, active)` returning an `OUT_W` vector.
- Sub-module `decoder_onehot`: purely combinational, parametrised `SEL_W`-to-`2**SEL_W` decoder with enable. It is instantiated once, driven by the `idx` and `active` registers. The sequencer and counter live in the top module.

## Test plan
- Reset then direct decode: with `SEL_W=3`, `en=1`, load `sel=5`, `mode=0` → next cycle `d=8'b0010_0000`, `idx=5`, `active=1`. It holds with `load=0` while `sel` changes.
- Full scan: `sel=0`, `last=7`, `dwell=2`, `mode=1` → `d` walks `0x01`, `0x02`, … `0x80`, each for 3 cycles. `wrap` pulses exactly once per 24 cycles, coincident with `d=0x01`.
- Partial scan with start beyond last: `sel=6`, `last=2`, `dwell=0` → `idx` sequence 6, 0, 1, 2, 0, 1, … with `wrap` on each step to 0.
- Live dwell shrink: in SCAN with `dwell=10` and `cnt=7`, drop `dwell` to 3 → step on the next edge, then 4-cycle holds.
- Priority: assert `load` and `en=0` together in SCAN → IDLE with `d=0` and `idx` unchanged. Then `load` with `en=1`, `mode=0`, `sel=3` → HOLD with `d=0x08`.
- Async reset mid-scan: pulse `rst_n` low between edges → `d=0`, `idx=0`, `active=0` immediately, and `wrap` stays 0 after release until the next load.
